tournament_predictor_ghr: RTL and testbench
===========================================

Name: tournament_predictor_ghr

Overview:
- Parametrised next-generation direction predictor for the fetch stage.
- Contains three counter tables:
  - bimodal, indexed by pc.
  - gshare, indexed by pc XOR global history.
  - chooser, indexed by pc.
- Owns the global history register (GHR) internally. The GHR is updated speculatively at predict time and repaired from the EX-stage snapshot on a mispredict.
- Tables are cleared by a post-reset sweep FSM. Predictions are registered, giving 1-cycle latency.

Parameters:
- ADDR_WIDTH, 29, width of the word-address pc.
- IDX_WIDTH, 10, log2 of entries per table.
- GHR_WIDTH, 10, global history length; must satisfy 2 <= GHR_WIDTH <= IDX_WIDTH.
- CTR_WIDTH, 2, saturating counter width; must be >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- ready  out  1  high once the table clear sweep has completed.
- pdc_valid  in  1  predict request.
- pc  in  ADDR_WIDTH  fetch pc.
- kind_pdc  in  3  predecoded branch kind.
- pdc_out_valid  out  1  registered response valid.
- taken_pdc  out  1  predicted direction.
- choice_pdc  out  1  chooser selection: 0 = bimodal, 1 = gshare.
- ghr_snapshot  out  GHR_WIDTH  GHR value used for this prediction (pre-shift).
- upd_valid  in  1  EX-stage resolve.
- pc_ex  in  ADDR_WIDTH  resolved pc.
- kind_ex  in  3  resolved kind.
- ghr_ex  in  GHR_WIDTH  snapshot carried down the pipe with the branch.
- taken_real  in  1  actual direction.
- mispredict  in  1  direction or target mispredict for this branch.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Kind encoding:
  - 0 NOT_JUMP, 1 DIRECT_JUMP, 2 JUMP, 3 CALL, 4 RET, 5 INDIRECT_JUMP, 6 OTHER_JUMP.
  - Conditional kinds are 1 and 6.
- Reset (async): FSM -> INIT, sweep index = 0, GHR = 0, ready = 0, pdc_out_valid = 0, taken_pdc = 0, choice_pdc = 0, ghr_snapshot = 0.
- FSM states:
  - INIT: each cycle writes entry[sweep] in all three tables.
    - Bimodal and gshare entries get 2^(CTR_WIDTH-1)-1 (weakly not-taken).
    - Chooser entries get 2^(CTR_WIDTH-1)-1 (weakly bimodal).
    - sweep increments each cycle; after writing entry 2^IDX_WIDTH-1 the FSM moves to RUN.
    - The sweep takes exactly 2^IDX_WIDTH cycles.
  - RUN: ready = 1. Never leaves RUN except via rst.
  - rst asserted mid-sweep restarts the sweep from 0.
- In INIT, pdc_valid and upd_valid are ignored: no table or GHR change, pdc_out_valid = 0.
- Indexing:
  - b_idx = pc[IDX_WIDTH-1:0].
  - g_idx = pc[IDX_WIDTH-1:0] XOR zero-extended GHR.
  - The update path uses pc_ex and ghr_ex the same way.
- Predict path, on a cycle with pdc_valid and ready:
  - Next cycle: pdc_out_valid = 1, ghr_snapshot = current GHR, choice_pdc = MSB of chooser[b_idx].
  - taken_pdc by kind:
    - Conditional: MSB of gshare[g_idx] if choice_pdc, else MSB of bimodal[b_idx].
    - Kinds 2, 3, 4, 5: 1.
    - Kind 0 and undefined encodings: 0.
  - Without pdc_valid, pdc_out_valid = 0 next cycle; the other outputs hold.
- Speculative GHR: on an accepted conditional predict, GHR <= {GHR[GHR_WIDTH-2:0], predicted taken}.
- Update path, on a cycle with upd_valid, ready and a conditional kind_ex:
  - Bimodal and gshare counters saturate: +1 if taken_real, else -1; clamped to 0 and 2^CTR_WIDTH-1.
  - Chooser is updated only when bimodal MSB != gshare MSB (values read before this update): +1 if gshare was correct, else -1, saturating.
  - Non-conditional kinds do not touch the tables.
- GHR repair, on upd_valid and mispredict:
  - Conditional kind_ex: GHR <= {ghr_ex[GHR_WIDTH-2:0], taken_real}.
  - Other kinds: GHR <= ghr_ex.
  - Repair overrides any speculative shift in the same cycle.
- Same-cycle read/write to the same entry: the read returns the pre-update value; the write lands at the clock edge.

Test Plan:
- Reset with IDX_WIDTH=4 -> ready = 0 for exactly 16 cycles, then 1. A predict with kind 1, any pc -> next-cycle taken_pdc = 0, choice_pdc = 0. Assert rst at sweep cycle 7 -> ready again low for a full 16 cycles.
- Kinds 2, 3, 4, 5 -> taken_pdc = 1; kind 0 and kind 7 -> 0; only kinds 1 and 6 shift the GHR.
- Two taken updates, kind 1, pc_ex = 0x5, ghr_ex = 0 -> bimodal[5] goes 1 -> 2 -> 3. Further taken updates stay 3. Then four not-taken updates -> 0 and saturate at 0.
- From GHR = 0: predicts kinds 1, 1 at pc 0 with predicted taken 0 then 1 -> ghr_snapshot = 0 then 0; GHR = 0b01. Then upd_valid, mispredict, kind 1, ghr_ex = 0b10, taken_real = 1 -> GHR = 0b101 (GHR_WIDTH=10), even with pdc_valid high in the same cycle.
- Chooser: pre-train gshare[g_idx] = 3 and bimodal[b_idx] = 0, then a taken update -> chooser[b_idx] increments 1 -> 2 and choice_pdc = 1. With both tables at 3, a taken update -> chooser unchanged.
- Predict and update to the same index in the same cycle -> response shows the old counter; the next predict shows the new one.

Source files
------------

// File: rtl/tournament_predictor_ghr.sv
// tournament_predictor_ghr: bimodal/gshare tournament direction predictor with a speculative, repairable global history
module tournament_predictor_ghr #(
  parameter int ADDR_WIDTH = 29,
  parameter int IDX_WIDTH = 10,
  parameter int GHR_WIDTH = 10,
  parameter int CTR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  pdc_valid,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [2:0]            kind_pdc,
  output logic                  pdc_out_valid,
  output logic                  taken_pdc,
  output logic                  choice_pdc,
  output logic [GHR_WIDTH-1:0]  ghr_snapshot,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] pc_ex,
  input  logic [2:0]            kind_ex,
  input  logic [GHR_WIDTH-1:0]  ghr_ex,
  input  logic                  taken_real,
  input  logic                  mispredict
);
  localparam int ENTRIES = 1 << IDX_WIDTH;
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nxt;
  logic [IDX_WIDTH-1:0] sweep;
  logic [GHR_WIDTH-1:0] ghr, ghr_nxt;
  logic [CTR_WIDTH-1:0] bim [ENTRIES];
  logic [CTR_WIDTH-1:0] gsh [ENTRIES];
  logic [CTR_WIDTH-1:0] cho [ENTRIES];
  logic [IDX_WIDTH-1:0] b_idx, g_idx, bu_idx, gu_idx;
  logic pdc_cond, upd_cond, pdc_go, upd_go, pred_taken, pred_choice, bu_msb, gu_msb;
  logic unused_bits;
  assign unused_bits = ^{pc[ADDR_WIDTH-1:IDX_WIDTH], pc_ex[ADDR_WIDTH-1:IDX_WIDTH]};
  function automatic logic [CTR_WIDTH-1:0] sat(input logic [CTR_WIDTH-1:0] c, input logic up);
    return up ? ((c == CTR_MAX) ? c : c + 1'b1) : ((c == '0) ? c : c - 1'b1);
  endfunction
  // indexing, predicted direction, history next-state and sweep completion
  always_comb begin
    ready = state == RUN;
    b_idx = pc[IDX_WIDTH-1:0];
    g_idx = b_idx ^ IDX_WIDTH'(ghr);
    bu_idx = pc_ex[IDX_WIDTH-1:0];
    gu_idx = bu_idx ^ IDX_WIDTH'(ghr_ex);
    pdc_cond = kind_pdc == 3'd1 || kind_pdc == 3'd6;
    upd_cond = kind_ex == 3'd1 || kind_ex == 3'd6;
    pdc_go = pdc_valid && ready;
    upd_go = upd_valid && ready && upd_cond;
    pred_choice = cho[b_idx][CTR_WIDTH-1];
    pred_taken = pdc_cond ? (pred_choice ? gsh[g_idx][CTR_WIDTH-1] : bim[b_idx][CTR_WIDTH-1])
                          : (kind_pdc >= 3'd2 && kind_pdc <= 3'd5);
    bu_msb = bim[bu_idx][CTR_WIDTH-1];
    gu_msb = gsh[gu_idx][CTR_WIDTH-1];
    ghr_nxt = (upd_valid && mispredict && ready) ? (upd_cond ? {ghr_ex[GHR_WIDTH-2:0], taken_real} : ghr_ex)
            : (pdc_go && pdc_cond) ? {ghr[GHR_WIDTH-2:0], pred_taken} : ghr;
    state_nxt = (state == INIT && sweep == '1) ? RUN : state;
  end
  // state, sweep pointer, history and registered prediction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      sweep <= '0;
      ghr <= '0;
      pdc_out_valid <= 1'b0;
      taken_pdc <= 1'b0;
      choice_pdc <= 1'b0;
      ghr_snapshot <= '0;
    end else begin
      state <= state_nxt;
      sweep <= (state == INIT) ? sweep + 1'b1 : sweep;
      ghr <= ghr_nxt;
      pdc_out_valid <= pdc_go;
      if (pdc_go) begin
        taken_pdc <= pred_taken;
        choice_pdc <= pred_choice;
        ghr_snapshot <= ghr;
      end
    end
  end
  // table clear sweep, then saturating training; chooser moves only when the components disagree
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      bim[sweep] <= CTR_INIT;
      gsh[sweep] <= CTR_INIT;
      cho[sweep] <= CTR_INIT;
    end else if (upd_go) begin
      bim[bu_idx] <= sat(bim[bu_idx], taken_real);
      gsh[gu_idx] <= sat(gsh[gu_idx], taken_real);
      if (bu_msb != gu_msb) cho[bu_idx] <= sat(cho[bu_idx], gu_msb == taken_real);
    end
  end
endmodule

// File: tb/tb_tournament_predictor_ghr.sv
// tb_tournament_predictor_ghr: directed self-checking bench for the tournament predictor
module tb_tournament_predictor_ghr;
  localparam int AW = 8, IW = 4, GW = 4, CW = 2;
  logic clk = 1'b0, rst = 1'b1, ready;
  logic pdc_valid = 1'b0, pdc_out_valid, taken_pdc, choice_pdc;
  logic [AW-1:0] pc = '0, pc_ex = '0;
  logic [2:0] kind_pdc = '0, kind_ex = '0;
  logic [GW-1:0] ghr_snapshot, ghr_ex = '0;
  logic upd_valid = 1'b0, taken_real = 1'b0, mispredict = 1'b0;
  logic [6:0] rsp;
  int checks = 0, failures = 0;
  assign rsp = {pdc_out_valid, taken_pdc, choice_pdc, ghr_snapshot};

  tournament_predictor_ghr #(.ADDR_WIDTH(AW), .IDX_WIDTH(IW), .GHR_WIDTH(GW), .CTR_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .ready(ready), .pdc_valid(pdc_valid), .pc(pc), .kind_pdc(kind_pdc),
    .pdc_out_valid(pdc_out_valid), .taken_pdc(taken_pdc), .choice_pdc(choice_pdc), .ghr_snapshot(ghr_snapshot),
    .upd_valid(upd_valid), .pc_ex(pc_ex), .kind_ex(kind_ex), .ghr_ex(ghr_ex), .taken_real(taken_real),
    .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic pv, input logic [2:0] pk, input logic [AW-1:0] p, input logic uv,
                     input logic [2:0] uk, input logic [AW-1:0] pe, input logic [GW-1:0] ge,
                     input logic tr, input logic mp);
    pdc_valid = pv; kind_pdc = pk; pc = p;
    upd_valid = uv; kind_ex = uk; pc_ex = pe; ghr_ex = ge; taken_real = tr; mispredict = mp;
    step();
    pdc_valid = 1'b0; upd_valid = 1'b0; mispredict = 1'b0;
  endtask

  task automatic pred(input logic [2:0] k, input logic [AW-1:0] p);
    cyc(1'b1, k, p, 1'b0, 3'd0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [2:0] k, input logic [AW-1:0] pe, input logic [GW-1:0] ge,
                     input logic tr, input logic mp);
    cyc(1'b0, 3'd0, '0, 1'b1, k, pe, ge, tr, mp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 40 && !ready; i++) step();
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready_timeout: ready=%b expected 1", ready); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++;
    if ({ready, rsp} !== 8'h00) begin failures++; $display("FAIL reset_outputs: got=%b expected 00000000", {ready, rsp}); end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ready !== 1'b0) begin failures++; $display("FAIL sweep_ready_low cycle=%0d: ready=%b expected 0", i, ready); end
      step();
    end
    checks++;
    if (ready !== 1'b1) begin failures++; $display("FAIL sweep_done: ready=%b expected 1", ready); end
    pred(3'd1, 8'd3);
    checks++;
    if (rsp !== 7'b1_0_0_0000) begin failures++; $display("FAIL first_predict: got=%b expected 1000000", rsp); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0) begin failures++; $display("FAIL midsweep_rst: ready=%b expected 0", ready); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({ready, pdc_out_valid} !== 2'b00) begin failures++; $display("FAIL resweep_ignore cycle=%0d: ready,valid=%b expected 00", i, {ready, pdc_out_valid}); end
      pdc_valid = 1'b1; kind_pdc = 3'd2; pc = 8'd0;
      upd_valid = 1'b1; kind_ex = 3'd1; pc_ex = 8'd3; ghr_ex = 4'hf; taken_real = 1'b1; mispredict = 1'b1;
      step();
    end
    pdc_valid = 1'b0; upd_valid = 1'b0; mispredict = 1'b0;
    checks++;
    if ({ready, pdc_out_valid} !== 2'b10) begin failures++; $display("FAIL resweep_done: ready,valid=%b expected 10", {ready, pdc_out_valid}); end
    pred(3'd0, 8'd0);
    checks++;
    if (rsp !== 7'b1_0_0_0000) begin failures++; $display("FAIL init_ghr_untouched: got=%b expected 1000000", rsp); end
    pred(3'd1, 8'd3);
    checks++;
    if (rsp !== 7'b1_0_0_0000) begin failures++; $display("FAIL init_table_untouched: got=%b expected 1000000", rsp); end
  endtask

  task automatic test_kinds();
    logic [6:0] e;
    for (int k = 0; k < 8; k++) begin
      pred(3'(k), 8'd0);
      e = {1'b1, (k >= 2 && k <= 5) ? 1'b1 : 1'b0, 1'b0, 4'h0};
      checks++;
      if (rsp !== e) begin failures++; $display("FAIL kind_%0d: got=%b expected %b", k, rsp, e); end
    end
    pred(3'd2, 8'd0);
    step();
    checks++;
    if (rsp !== 7'b0_1_0_0000) begin failures++; $display("FAIL idle_hold: got=%b expected 0100000", rsp); end
  endtask

  task automatic test_bimodal();
    logic tr_v [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    logic ex_v [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    logic [GW-1:0] g = '0;
    logic [6:0] e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      upd(3'd1, 8'd5, 4'd0, tr_v[i], 1'b0);
      pred(3'd1, 8'd5);
      e = {1'b1, ex_v[i], 1'b0, g};
      checks++;
      if (rsp !== e) begin failures++; $display("FAIL bimodal_step_%0d: got=%b expected %b", i, rsp, e); end
      g = {g[GW-2:0], ex_v[i]};
    end
  endtask

  task automatic test_ghr();
    do_reset();
    pred(3'd1, 8'd0);
    checks++;
    if (rsp !== 7'b1_0_0_0000) begin failures++; $display("FAIL ghr_pred0: got=%b expected 1000000", rsp); end
    upd(3'd1, 8'd0, 4'd0, 1'b1, 1'b0);
    pred(3'd1, 8'd0);
    checks++;
    if (rsp !== 7'b1_1_0_0000) begin failures++; $display("FAIL ghr_pred1: got=%b expected 1100000", rsp); end
    pred(3'd2, 8'd0);
    checks++;
    if (rsp !== 7'b1_1_0_0001) begin failures++; $display("FAIL ghr_after_shift: got=%b expected 1100001", rsp); end
    pred(3'd0, 8'd0);
    checks++;
    if (rsp !== 7'b1_0_0_0001) begin failures++; $display("FAIL ghr_kind2_noshift: got=%b expected 1000001", rsp); end
    pred(3'd6, 8'd0);
    checks++;
    if (rsp !== 7'b1_1_0_0001) begin failures++; $display("FAIL ghr_kind6: got=%b expected 1100001", rsp); end
    pred(3'd0, 8'd0);
    checks++;
    if (rsp !== 7'b1_0_0_0011) begin failures++; $display("FAIL ghr_kind6_shift: got=%b expected 1000011", rsp); end
    cyc(1'b1, 3'd1, 8'd0, 1'b1, 3'd1, 8'd0, 4'b0010, 1'b1, 1'b1);
    checks++;
    if (rsp !== 7'b1_1_0_0011) begin failures++; $display("FAIL ghr_repair_pred: got=%b expected 1100011", rsp); end
    pred(3'd0, 8'd0);
    checks++;
    if (rsp !== 7'b1_0_0_0101) begin failures++; $display("FAIL ghr_repair_cond: got=%b expected 1000101", rsp); end
    upd(3'd4, 8'd0, 4'b1001, 1'b0, 1'b1);
    pred(3'd0, 8'd0);
    checks++;
    if (rsp !== 7'b1_0_0_1001) begin failures++; $display("FAIL ghr_repair_noncond: got=%b expected 1001001", rsp); end
  endtask

  task automatic test_chooser();
    do_reset();
    for (int i = 0; i < 3; i++) upd(3'd1, 8'd4, 4'd0, 1'b1, 1'b0);
    pred(3'd1, 8'd4);
    checks++;
    if (rsp !== 7'b1_1_0_0000) begin failures++; $display("FAIL chooser_agree_hold: got=%b expected 1100000", rsp); end
    upd(3'd1, 8'd2, 4'd0, 1'b0, 1'b0);
    upd(3'd1, 8'd6, 4'd0, 1'b1, 1'b0);
    upd(3'd1, 8'd6, 4'd0, 1'b1, 1'b0);
    upd(3'd1, 8'd2, 4'd4, 1'b1, 1'b0);
    upd(3'd4, 8'd0, 4'd4, 1'b0, 1'b1);
    pred(3'd1, 8'd2);
    checks++;
    if (rsp !== 7'b1_1_1_0100) begin failures++; $display("FAIL chooser_to_gshare: got=%b expected 1110100", rsp); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc(1'b1, 3'd1, 8'd3, 1'b1, 3'd1, 8'd3, 4'd0, 1'b1, 1'b0);
    checks++;
    if (rsp !== 7'b1_0_0_0000) begin failures++; $display("FAIL same_cycle_old: got=%b expected 1000000", rsp); end
    pred(3'd1, 8'd3);
    checks++;
    if (rsp !== 7'b1_1_0_0000) begin failures++; $display("FAIL same_cycle_new: got=%b expected 1100000", rsp); end
  endtask

  initial begin
    test_reset();
    test_kinds();
    test_bimodal();
    test_ghr();
    test_chooser();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
